// File: rtl/sp_ram_be_clr.sv
// Single-port synchronous RAM with byte-lane write enables and a selectable read-during-write mode.
// An optional output register adds a second stage, and an optional sweep zeroes the array after reset.
module sp_ram_be_clr #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);

    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("sp_ram_be_clr: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("sp_ram_be_clr: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_vld_q, s1_vld_d;

    logic                  accept_s;
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;
    logic [DATA_WIDTH-1:0] old_word_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  mem_we_s;
    logic [IDX_W-1:0]      mem_wa_s;
    logic [DATA_WIDTH-1:0] mem_wd_s;

    assign busy       = (state_q == ST_CLEAR);
    assign accept_s   = en && !busy;
    assign in_range_s = ({1'b0, address} < DEPTH_A);
    assign idx_s      = address[IDX_W-1:0];
    assign old_word_s = in_range_s ? mem_q[idx_s] : {DATA_WIDTH{1'b0}};

    // Clear sweep: one location per clock, then idle for good.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = {IDX_W{1'b0}};
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = {IDX_W{1'b0}};
            end
        endcase
    end

    // Byte-lane merge of write data over the current word.
    always_comb begin
        merged_s = old_word_s;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                merged_s[8*b +: 8] = data_in[8*b +: 8];
            end else begin
                merged_s[8*b +: 8] = old_word_s[8*b +: 8];
            end
        end
    end

    // Single write port shared by the clear sweep and user writes; out-of-range writes drop.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            mem_we_s = 1'b1;
            mem_wa_s = clr_cnt_q;
            mem_wd_s = {DATA_WIDTH{1'b0}};
        end else if (rst_n && accept_s && we && in_range_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = idx_s;
            mem_wd_s = merged_s;
        end else begin
            mem_we_s = 1'b0;
            mem_wa_s = idx_s;
            mem_wd_s = merged_s;
        end
    end

    // First output stage: read data and valid, with read-during-write selection.
    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = 1'b0;
        if (accept_s && !we) begin
            s1_data_d = old_word_s;
            s1_vld_d  = 1'b1;
        end else if (accept_s && we) begin
            case (RDW_MODE)
                WRITE_FIRST: begin
                    s1_data_d = in_range_s ? merged_s : {DATA_WIDTH{1'b0}};
                    s1_vld_d  = 1'b1;
                end
                READ_FIRST: begin
                    s1_data_d = old_word_s;
                    s1_vld_d  = 1'b1;
                end
                default: begin
                    s1_data_d = s1_data_q;
                    s1_vld_d  = 1'b0;
                end
            endcase
        end else begin
            s1_data_d = s1_data_q;
            s1_vld_d  = 1'b0;
        end
    end

    // Storage array; contents survive reset and are zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    // Control and first-stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= {IDX_W{1'b0}};
            s1_data_q <= {DATA_WIDTH{1'b0}};
            s1_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_vld_q;

        // Second output stage delays data and valid together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data_q <= {DATA_WIDTH{1'b0}};
                s2_vld_q  <= 1'b0;
            end else begin
                s2_data_q <= s1_data_q;
                s2_vld_q  <= s1_vld_q;
            end
        end

        assign data_out = s2_data_q;
        assign rd_valid = s2_vld_q;
    end else begin : g_no_out_reg
        assign data_out = s1_data_q;
        assign rd_valid = s1_vld_q;
    end

endmodule
